tape_ear_filter: RTL and testbench



---
 rtl/tape_ear_filter_pkg.sv | 10 +
 rtl/tape_ear_filter_if.sv | 11 +
 rtl/tape_ear_filter_ear_debounce.sv | 38 +++
 rtl/tape_ear_filter.sv | 51 +++++
 tb/tb_tape_ear_filter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/tape_ear_filter_pkg.sv
// tape_pkg: shared widths, defaults and saturating helper for the tape EAR filter
package tape_pkg;
   localparam int PERIOD_W = 16;
   localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
   localparam int DEF_FILTER_LEN = 16;
   localparam int DEF_ACT_W = 20;
   function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
      return (v == PERIOD_MAX) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/tape_ear_filter_if.sv
// tape_ear_filter_if: tape source selection inputs and conditioned EAR outputs
interface tape_ear_filter_if;
   import tape_pkg::*;
   logic ce, ear_raw, adc_bit, adc_active, src_sel;
   logic ear, ear_edge, rise, period_valid, active;
   logic [PERIOD_W-1:0] period;
   modport master (output ce, ear_raw, adc_bit, adc_active, src_sel,
                   input ear, ear_edge, rise, period, period_valid, active);
   modport slave (input ce, ear_raw, adc_bit, adc_active, src_sel,
                  output ear, ear_edge, rise, period, period_valid, active);
endinterface

// File: rtl/tape_ear_filter_ear_debounce.sv
// ear_debounce: two-flop synchroniser plus stability filter with edge strobes
module ear_debounce
   import tape_pkg::*;
#(
   parameter int FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic ce,
   input  logic din,
   output logic ear,
   output logic ear_edge,
   output logic rise,
   output logic accept
);
   logic s1, s2;
   logic [7:0] cnt;
   assign accept = ce && (s2 != ear) && (cnt == 8'(FILTER_LEN - 1));
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         cnt <= '0;
         ear <= 1'b0;
         ear_edge <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         ear_edge <= accept;
         rise <= accept & s2;
         if (ce) begin
            cnt <= (s2 == ear || accept) ? '0 : cnt + 1'b1;
            if (accept) ear <= s2;
         end
      end
   end
endmodule

// File: rtl/tape_ear_filter.sv
// tape_ear_filter: selects tape source, debounces it, and measures rise period and activity
module tape_ear_filter
   import tape_pkg::*;
#(
   parameter int FILTER_LEN = DEF_FILTER_LEN,
   parameter int ACT_W = DEF_ACT_W
) (
   input logic clk_sys,
   input logic reset,
   tape_ear_filter_if.slave bus
);
   logic src, ear, ear_edge, rise, accept, rise_now, period_valid, seen_rise;
   logic [PERIOD_W-1:0] pcnt, period;
   logic [ACT_W-1:0] acnt;
   assign src = bus.src_sel ? (bus.adc_bit & bus.adc_active) : bus.ear_raw;
   ear_debounce #(.FILTER_LEN(FILTER_LEN)) u_debounce (
      .clk_sys(clk_sys),
      .reset(reset),
      .ce(bus.ce),
      .din(src),
      .ear(ear),
      .ear_edge(ear_edge),
      .rise(rise),
      .accept(accept)
   );
   // acceptance is combinational so period bookkeeping lands on the same edge as ear
   assign rise_now = accept & ~ear;
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pcnt <= '0;
         period <= '0;
         period_valid <= 1'b0;
         seen_rise <= 1'b0;
         acnt <= '0;
      end else begin
         period_valid <= rise_now & seen_rise;
         if (rise_now) begin
            period <= sat_inc(pcnt);
            pcnt <= '0;
            seen_rise <= 1'b1;
         end else if (bus.ce) pcnt <= sat_inc(pcnt);
         acnt <= accept ? '1 : (bus.ce && acnt != '0) ? acnt - 1'b1 : acnt;
      end
   end
   assign bus.ear = ear;
   assign bus.ear_edge = ear_edge;
   assign bus.rise = rise;
   assign bus.period = period;
   assign bus.period_valid = period_valid;
   assign bus.active = |acnt;
endmodule

// File: tb/tb_tape_ear_filter.sv
// tb_tape_ear_filter: two filter configurations against a window-based reference model
module tb_tape_ear_filter;
   import tape_pkg::*;
   localparam int LA = 16, AWA = 20, LB = 1, AWB = 4;
   logic clk_sys = 1'b0, reset = 1'b1, ce = 1'b1;
   logic ear_raw = 1'b0, adc_bit = 1'b0, adc_active = 1'b0, src_sel = 1'b0;
   logic r_rst = 1'b1, r_ce = 1'b0, r_src = 1'b0;
   int checks = 0, errors = 0;
   int ce_idx[2], last_tog[2], last_rise[2], last_edge[2], period_m[2];
   bit p1[2], p2[2], ear_m[2], edge_m[2], rise_m[2], pv_m[2], seen[2], had_edge[2];
   bit hist[2][256];
   always #5 clk_sys = ~clk_sys;
   tape_ear_filter_if bus_a();
   tape_ear_filter_if bus_b();
   assign bus_a.ce = ce;
   assign bus_a.ear_raw = ear_raw;
   assign bus_a.adc_bit = adc_bit;
   assign bus_a.adc_active = adc_active;
   assign bus_a.src_sel = src_sel;
   assign bus_b.ce = ce;
   assign bus_b.ear_raw = ear_raw;
   assign bus_b.adc_bit = adc_bit;
   assign bus_b.adc_active = adc_active;
   assign bus_b.src_sel = src_sel;
   tape_ear_filter #(.FILTER_LEN(LA), .ACT_W(AWA)) dut_a (.clk_sys(clk_sys), .reset(reset), .bus(bus_a));
   tape_ear_filter #(.FILTER_LEN(LB), .ACT_W(AWB)) dut_b (.clk_sys(clk_sys), .reset(reset), .bus(bus_b));
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // ear toggles once the last L ce-samples since the previous toggle all disagree with it
   task automatic model_step(int k, int L);
      bit s2, ok;
      edge_m[k] = 0; rise_m[k] = 0; pv_m[k] = 0;
      if (r_rst) begin
         ce_idx[k] = 0; last_tog[k] = 0; last_rise[k] = 0; last_edge[k] = 0; period_m[k] = 0;
         p1[k] = 0; p2[k] = 0; ear_m[k] = 0; seen[k] = 0; had_edge[k] = 0;
         return;
      end
      s2 = p2[k]; p2[k] = p1[k]; p1[k] = r_src;
      if (!r_ce) return;
      ce_idx[k]++;
      hist[k][8'(ce_idx[k])] = s2;
      ok = (ce_idx[k] - last_tog[k]) >= L;
      if (ok) for (int j = 0; j < L; j++) if (hist[k][8'(ce_idx[k] - j)] == ear_m[k]) ok = 0;
      if (!ok) return;
      ear_m[k] = s2; last_tog[k] = ce_idx[k]; edge_m[k] = 1; rise_m[k] = s2;
      last_edge[k] = ce_idx[k]; had_edge[k] = 1;
      if (s2) begin
         period_m[k] = (ce_idx[k] - last_rise[k] > 65535) ? 65535 : ce_idx[k] - last_rise[k];
         pv_m[k] = seen[k]; seen[k] = 1; last_rise[k] = ce_idx[k];
      end
   endtask
   function automatic bit act_m(int k, int aw);
      return had_edge[k] && (ce_idx[k] - last_edge[k]) < (2 ** aw - 1);
   endfunction
   always @(posedge clk_sys) begin
      r_rst <= reset;
      r_ce <= ce;
      r_src <= src_sel ? (adc_bit & adc_active) : ear_raw;
   end
   always @(negedge clk_sys) begin
      model_step(0, LA);
      model_step(1, LB);
      check("a_ear", 32'(bus_a.ear), 32'(ear_m[0]));
      check("a_edge", 32'(bus_a.ear_edge), 32'(edge_m[0]));
      check("a_rise", 32'(bus_a.rise), 32'(rise_m[0]));
      check("a_pvalid", 32'(bus_a.period_valid), 32'(pv_m[0]));
      check("a_period", 32'(bus_a.period), 32'(period_m[0]));
      check("a_active", 32'(bus_a.active), 32'(act_m(0, AWA)));
      check("b_ear", 32'(bus_b.ear), 32'(ear_m[1]));
      check("b_edge", 32'(bus_b.ear_edge), 32'(edge_m[1]));
      check("b_rise", 32'(bus_b.rise), 32'(rise_m[1]));
      check("b_pvalid", 32'(bus_b.period_valid), 32'(pv_m[1]));
      check("b_period", 32'(bus_b.period), 32'(period_m[1]));
      check("b_active", 32'(bus_b.active), 32'(act_m(1, AWB)));
      check("strobe_without_ce", 32'((bus_a.ear_edge | bus_b.ear_edge | bus_a.period_valid) & ~r_ce), 32'd0);
   end
   task automatic cyc(int n);
      repeat (n) @(negedge clk_sys);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask
   task automatic measure(string tag, bit lvl, int exp_a, int exp_b);
      int na = 0, nb = 0;
      for (int n = 1; n <= 100 && (na == 0 || nb == 0); n++) begin
         @(negedge clk_sys);
         if (na == 0 && bus_a.ear == lvl) na = n;
         if (nb == 0 && bus_b.ear == lvl) nb = n;
      end
      check({tag, "_lat_a"}, 32'(na), 32'(exp_a));
      check({tag, "_lat_b"}, 32'(nb), 32'(exp_b));
   endtask
   initial begin
      int n, npv, first, hold;
      cyc(3);
      reset = 1'b0;
      cyc(2);
      ear_raw = 1'b1;
      measure("step_up", 1'b1, LA + 2, LB + 2);
      cyc(20);
      check("step_active", 32'(bus_a.active), 32'd1);
      ear_raw = 1'b0;
      measure("step_dn", 1'b0, LA + 2, LB + 2);
      cyc(5);
      n = 0;
      ear_raw = 1'b1;
      for (int i = 0; i < 45; i++) begin
         if (i == 15) ear_raw = 1'b0;
         @(negedge clk_sys);
         n += int'(bus_a.ear_edge);
      end
      check("glitch_edges", 32'(n), 32'd0);
      check("glitch_ear", 32'(bus_a.ear), 32'd0);
      do_reset();
      npv = 0;
      for (int i = 0; i < 4030; i++) begin
         ear_raw = (i < 4000) && ((i % 1000) < 500);
         @(negedge clk_sys);
         if (bus_a.period_valid) begin
            npv++;
            check("sq_period", 32'(bus_a.period), 32'd1000);
         end
      end
      check("sq_pv_cnt", 32'(npv), 32'd3);
      first = -1;
      for (int i = 0; i < 200; i++) begin
         ce = (i % 4) == 0;
         ear_raw = i >= 8;
         @(negedge clk_sys);
         if (first < 0 && bus_a.ear) first = i;
      end
      ce = 1'b1;
      check("ce4_lat", 32'(first), 32'(8 + 4 + 4 * (LA - 1)));
      do_reset();
      src_sel = 1'b1;
      for (int i = 0; i < 200; i++) begin
         adc_bit = ((i / 10) % 2) == 1;
         @(negedge clk_sys);
      end
      check("adc_off_ear_a", 32'(bus_a.ear), 32'd0);
      check("adc_off_ear_b", 32'(bus_b.ear), 32'd0);
      adc_bit = 1'b0;
      adc_active = 1'b1;
      cyc(30);
      adc_bit = 1'b1;
      measure("adc", 1'b1, LA + 2, LB + 2);
      cyc(40);
      check("act_b_idle", 32'(bus_b.active), 32'd0);
      check("act_a_busy", 32'(bus_a.active), 32'd1);
      src_sel = 1'b0;
      ear_raw = 1'b0;
      cyc(10);
      reset = 1'b1;
      cyc(1);
      check("rst_ear", 32'(bus_a.ear), 32'd0);
      check("rst_period", 32'(bus_a.period), 32'd0);
      check("rst_active", 32'(bus_a.active), 32'd0);
      reset = 1'b0;
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            ear_raw = 1'($urandom);
            adc_bit = 1'($urandom);
            hold = int'($urandom_range(1, 40));
         end
         hold--;
         ce = ($urandom % 4) != 0;
         if ($urandom % 300 == 0) src_sel = ~src_sel;
         if ($urandom % 400 == 0) adc_active = ~adc_active;
         reset = ($urandom % 1500) == 0;
         @(negedge clk_sys);
      end
      reset = 1'b0;
      ce = 1'b1;
      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
